// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search block.
package sar_pkg;

    localparam int unsigned SAR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-index width; at least one bit so a 1-bit search still has a legal index.
    function automatic int unsigned idx_bits(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sar_step.sv
// One SAR bisection step: resolve the current bit from the compare and form the next trial.
module sar_step
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_WIDTH,
    parameter int unsigned IDX_W = idx_bits(SAR_WIDTH)
) (
    input  logic [WIDTH-1:0] trial,
    input  logic [IDX_W-1:0] idx,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] kept_c,
    output logic [WIDTH-1:0] next_c,
    output logic             onehot_c
);

    logic [WIDTH-1:0] bit_mask;

    always_comb begin
        bit_mask = WIDTH'(1) << idx;
        // target below trial clears the bit under test; gt (and eq without early exit) keeps it
        kept_c   = cmp_lt ? (trial & ~bit_mask) : trial;
        next_c   = (idx == '0) ? kept_c : (kept_c | (bit_mask >> 1));
        // odd count of asserted flags, excluding all three
        onehot_c = (cmp_gt ^ cmp_eq ^ cmp_lt) & ~(cmp_gt & cmp_eq & cmp_lt);
    end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search FSM driving an external comparator.
// Define SAR_EARLY_EXIT_EN to end a search as soon as the comparator reports equality.
module sar_search
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         cmp_gt,
    input  logic                         cmp_eq,
    input  logic                         cmp_lt,
    output logic [WIDTH-1:0]             trial,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             result,
    output logic [$clog2(WIDTH+1)-1:0]   steps,
    output logic                         err
);

    localparam int unsigned IDX_W   = idx_bits(WIDTH);
    localparam int unsigned STEPS_W = $clog2(WIDTH + 1);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [WIDTH-1:0]   trial_n, result_n;
    logic [STEPS_W-1:0] steps_n;
    logic               busy_n, done_n, err_n;

    logic [WIDTH-1:0]   kept_c, next_c;
    logic               onehot_c, eq_exit_c;

    sar_step #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_step (
        .trial    (trial),
        .idx      (idx),
        .cmp_gt   (cmp_gt),
        .cmp_eq   (cmp_eq),
        .cmp_lt   (cmp_lt),
        .kept_c   (kept_c),
        .next_c   (next_c),
        .onehot_c (onehot_c)
    );

`ifdef SAR_EARLY_EXIT_EN
    assign eq_exit_c = cmp_eq;
`else
    assign eq_exit_c = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            trial  <= '0;
            result <= '0;
            steps  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            trial  <= trial_n;
            result <= result_n;
            steps  <= steps_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        trial_n  = trial;
        result_n = result;
        steps_n  = steps;
        err_n    = err;
        busy_n   = 1'b0;
        done_n   = 1'b0;

        unique case (state)
            IDLE: begin
                trial_n = '0;
                if (start) begin
                    err_n   = 1'b0;
                    steps_n = '0;
                    idx_n   = IDX_W'(WIDTH - 1);
                    trial_n = WIDTH'(1) << (WIDTH - 1);
                    busy_n  = 1'b1;
                    state_n = TEST;
                end
            end
            TEST: begin
                steps_n = steps + STEPS_W'(1);
                busy_n  = 1'b1;
                if (!onehot_c) begin
                    err_n    = 1'b1;
                    result_n = '0;
                end else if (eq_exit_c) begin
                    result_n = trial;
                end else if (idx == '0) begin
                    result_n = kept_c;
                end else begin
                    trial_n = next_c;
                    idx_n   = idx - IDX_W'(1);
                end
                // every branch except a normal bisection step finishes the search
                if (!onehot_c || eq_exit_c || idx == '0) begin
                    trial_n = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                trial_n = '0;
                state_n = IDLE;
            end
            default: begin
                trial_n = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search with a behavioural comparator and a programmable target.
module tb_sar_search;
    import sar_pkg::*;

    localparam int W  = SAR_WIDTH;
    localparam int SW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cmp_gt, cmp_eq, cmp_lt;
    logic [W-1:0]  trial;
    logic          busy, done, err;
    logic [W-1:0]  result;
    logic [SW-1:0] steps;

    int  target    = 0;
    bit  force_err = 1'b0;
    int  cyc       = 0;
    int  checks    = 0;
    int  errors    = 0;
    int  done_cnt  = 0;
    bit  prev_done = 1'b0;

    typedef struct {
        int result;
        int steps;
        int err;
        int start_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   trial_q[$];
    exp_t e;

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .steps  (steps),
        .err    (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator of target vs trial, with an override producing an illegal gt+lt pattern
    always_comb begin
        if (force_err) begin
            cmp_gt = 1'b1;
            cmp_eq = 1'b0;
            cmp_lt = 1'b1;
        end else begin
            cmp_gt = (target > int'(trial));
            cmp_eq = (target == int'(trial));
            cmp_lt = (target < int'(trial));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Binary search on a power-of-two range hits the target once the probed bit is its lowest set bit
    function automatic int model_steps(input int tgt);
`ifdef SAR_EARLY_EXIT_EN
        for (int b = 0; b < W; b++)
            if (((tgt >> b) & 1) == 1) return W - b;
`endif
        return W;
    endfunction

    task automatic push_search(input int tgt, input bit ferr, input int sc);
        exp_t x;
        int   s;
        if (ferr) begin
            trial_q.push_back(1 << (W - 1));
            x = '{result: 0, steps: 1, err: 1, start_cyc: sc};
        end else begin
            s = model_steps(tgt);
            // k-th probe: target's bits above the probed bit, probed bit set, rest clear
            for (int k = 1; k <= s; k++)
                trial_q.push_back(((tgt >> (W - k + 1)) << (W - k + 1)) | (1 << (W - k)));
            x = '{result: tgt, steps: s, err: 0, start_cyc: sc};
        end
        exp_q.push_back(x);
    endtask

    // Monitor: trial sequence while busy, full result at each done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                chk("done_while_busy", int'(done), 0);
                if (trial_q.size() == 0) chk("busy_unexpected", 1, 0);
                else chk("trial", int'(trial), trial_q.pop_front());
            end
            if (done) begin
                chk("done_one_cycle", int'(prev_done), 0);
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result",     int'(result), e.result);
                    chk("steps",      int'(steps),  e.steps);
                    chk("err",        int'(err),    e.err);
                    chk("latency",    cyc - e.start_cyc, e.steps);
                    chk("trial_done", int'(trial),  0);
                    chk("busy_done",  int'(busy),   0);
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic run_search(input int tgt, input bit ferr);
        int base;
        @(posedge clk); #1;
        target    = tgt;
        force_err = ferr;
        base      = done_cnt;
        push_search(tgt, ferr, cyc + 1);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        for (int i = 0; i < W + 4 && done_cnt == base; i++) @(posedge clk);
        chk("done_count", done_cnt - base, 1);
        force_err = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_trial"},  int'(trial),  0);
        chk({tag, "_busy"},   int'(busy),   0);
        chk({tag, "_done"},   int'(done),   0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_steps"},  int'(steps),  0);
        chk({tag, "_err"},    int'(err),    0);
    endtask

    initial begin
        int s, n, base;
        rst_n = 1'b0;
        start = 1'b0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed targets: mid-range, power of two, both extremes
        run_search(11, 1'b0);
        run_search(4,  1'b0);
        run_search(0,  1'b0);
        run_search(15, 1'b0);

        // Illegal compare on the first TEST cycle
        run_search(9, 1'b1);
        run_search(6, 1'b0);

        for (int i = 0; i < 16; i++)
            run_search(int'($urandom_range(0, (1 << W) - 1)), 1'b0);

        // start held high: one search per IDLE visit, never queued
        @(posedge clk); #1;
        target = 13;
        s      = model_steps(13);
        n      = 2 * (s + 2) + 1;
        base   = done_cnt;
        for (int k = 0; k < 3; k++) push_search(13, 1'b0, cyc + 1 + k * (s + 2));
        start = 1'b1;
        repeat (n) @(posedge clk);
        #1 start = 1'b0;
        repeat (W + 4) @(posedge clk);
        chk("held_start_searches", done_cnt - base, 3);

        // Reset during the second TEST cycle
        @(posedge clk); #1;
        target = 7;
        push_search(7, 1'b0, cyc + 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        trial_q.delete();
        exp_q.delete();
        base = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(posedge clk);
        chk("no_done_after_reset", done_cnt - base, 0);

        run_search(5, 1'b0);

        repeat (2) @(posedge clk);
        chk("leftover_trials",  trial_q.size(), 0);
        chk("leftover_results", exp_q.size(),   0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the search width in bits (values 0 to 2^WIDTH-1).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, which requests a new search.
REQ-005 SHALL have ports cmp_gt, cmp_eq and cmp_lt, each an input of 1 bit, from an external combinational comparator of target vs trial: target>trial, target==trial and target<trial respectively.
REQ-006 SHALL have port trial, output, WIDTH bits, the value presented to the comparator.
REQ-007 SHALL have port busy, output, 1 bit, high while a search is in progress.
REQ-008 SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-009 SHALL have port result, output, WIDTH bits, the resolved target, held until the next start.
REQ-010 SHALL have port steps, output, ceil(log2(WIDTH+1)) bits, the number of TEST cycles the last search used.
REQ-011 SHALL have port err, output, 1 bit, high when the last search saw a non-one-hot compare; held until the next start.

Function
REQ-012 SHALL implement the FSM states IDLE, TEST and DONE; reset enters IDLE.
REQ-013 IDLE: start=1 SHALL, at the next edge, clear err and steps, set the bit index to WIDTH-1 and trial to 2^(WIDTH-1), then move to TEST.
REQ-014 TEST SHALL sample the cmp_* inputs each cycle.
- cmp_gt=1: keep the current bit.
- cmp_lt=1: clear the current bit.
- In both cases, then set the next lower bit; steps increments by 1.
REQ-015 TEST with cmp_eq=1 SHALL load result=trial and go to DONE; steps includes this cycle.
REQ-016 After bit 0 is resolved without eq, the FSM SHALL load result with the kept bits and go to DONE; steps=WIDTH.
REQ-017 In TEST, if cmp_gt/eq/lt is not exactly one-hot, the FSM SHALL set err=1 and result=0 and go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE; trial SHALL be 0 in IDLE and DONE.
REQ-019 busy SHALL be 1 exactly in TEST.
REQ-020 start while in TEST or DONE SHALL be ignored and SHALL NOT be queued.
REQ-021 Latency SHALL be at most WIDTH+2 cycles from the start edge to the done pulse.

Reset
REQ-022 On rst_n low, the block SHALL asynchronously force IDLE with trial=0, busy=0, done=0, result=0, steps=0 and err=0, including mid-search; no done pulse follows.

Configuration
REQ-023 The macro SAR_EARLY_EXIT_EN SHALL control early exit on equality.
- Defined: cmp_eq terminates the search per REQ-015.
- Undefined: cmp_eq is treated as cmp_gt (keep bit), every search takes exactly WIDTH TEST cycles, and steps=WIDTH.
- The one-hot check applies in both cases.

Structure
REQ-024 The shared package sar_pkg SHALL hold the state enum (IDLE/TEST/DONE) and the default width constant SAR_WIDTH=4.
REQ-025 The next-trial/keep-clear logic SHALL be the sub-module sar_step (combinational); the FSM and registers stay in sar_search.

Verification
REQ-026 Bench SHALL pair the DUT with a behavioral comparator model of a programmable target and cover:
- Target 11, macro defined: trials 8, 12, 10, 11 -> done, result=11, steps=4, err=0.
- Target 4, macro defined: trials 8, 4 -> result=4, steps=2. Macro undefined: trials 8, 4, 6, 5 -> result=4, steps=4.
- Targets 0 and 15: trials 8, 4, 2, 1 -> result=0; trials 8, 12, 14, 15 -> result=15; both steps=4.
- Forced cmp_gt=cmp_lt=1 on the first TEST -> err=1, result=0, done pulse on the following cycle.
- Reset: rst_n low during the second TEST -> all outputs 0 immediately, no done. Start held high through a whole search -> exactly one search per IDLE visit.
